// File: rtl/ahb3lite_slave_arbiter.sv
// ahb3lite_slave_arbiter: per-slave AHB-Lite arbiter with fixed, round-robin and weighted modes plus starvation override
module ahb3lite_slave_arbiter #(
    parameter int MASTERS      = 3,
    parameter int MASTER_BITS  = (MASTERS == 1) ? 1 : $clog2(MASTERS),
    parameter int ARB_MODE     = 0,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                           HCLK,
    input  logic                           HRESETn,
    input  logic [MASTERS*MASTER_BITS-1:0] mst_priority,
    input  logic [MASTERS-1:0]             mst_HSEL,
    input  logic [2*MASTERS-1:0]           mst_HTRANS,
    input  logic [3*MASTERS-1:0]           mst_HBURST,
    input  logic [MASTERS-1:0]             mst_HMASTLOCK,
    input  logic [MASTERS-1:0]             can_switch,
    input  logic                           slv_HREADY,
    output logic [MASTERS-1:0]             granted_master,
    output logic [MASTER_BITS-1:0]         grant_idx,
    output logic                           grant_valid,
    output logic [MASTERS-1:0]             data_master,
    output logic [MASTERS-1:0]             starved
);

    localparam int WW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int CW = MASTER_BITS + 1;

    logic [MASTER_BITS-1:0] grant_idx_q, grant_idx_d, last_q, last_d;
    logic [3:0]             burst_cnt_q, burst_cnt_d;
    logic [CW-1:0]          credit_q, credit_d;
    logic [MASTERS-1:0]     data_q, data_d;
    logic [WW-1:0]          wait_q [MASTERS];
    logic [WW-1:0]          wait_d [MASTERS];

    logic [MASTERS-1:0]     req;
    logic [MASTER_BITS-1:0] prio [MASTERS];
    logic                   own_req, own_lock, own_sw, acc_ns, acc_seq, hold, arb, keep;
    logic [1:0]             own_trans;
    logic [2:0]             own_burst;
    logic [3:0]             burst_load;
    logic [CW-1:0]          credit_left;
    logic                   fp_found, rr_found, st_found;
    logic [MASTER_BITS-1:0] fp_idx, fp_prio, rr_idx, st_idx, win_idx, win_prio;

    assign grant_idx   = grant_idx_q;
    assign grant_valid = own_req;
    assign data_master = data_q;

    // Owner decode, burst/credit bookkeeping, winner selection and starvation counters
    always_comb begin
        int j;
        own_req   = 1'b0;
        own_lock  = 1'b0;
        own_sw    = 1'b0;
        own_trans = 2'b00;
        own_burst = 3'b000;
        for (int m = 0; m < MASTERS; m++) begin
            req[m]            = mst_HSEL[m] & (mst_HTRANS[2*m +: 2] != 2'b00);
            prio[m]           = mst_priority[m*MASTER_BITS +: MASTER_BITS];
            granted_master[m] = grant_idx_q == MASTER_BITS'(m);
            starved[m]        = (STARVE_LIMIT != 0) && (wait_q[m] == WW'(STARVE_LIMIT));
            if (granted_master[m]) begin
                own_req   = req[m];
                own_lock  = mst_HMASTLOCK[m];
                own_sw    = can_switch[m];
                own_trans = mst_HTRANS[2*m +: 2];
                own_burst = mst_HBURST[3*m +: 3];
            end
        end
        acc_ns      = slv_HREADY & own_req & (own_trans == 2'b10);
        acc_seq     = slv_HREADY & own_req & (own_trans == 2'b11);
        burst_load  = (own_burst < 3'd2) ? 4'd0 : (own_burst < 3'd4) ? 4'd3 : (own_burst < 3'd6) ? 4'd7 : 4'd15;
        burst_cnt_d = acc_ns ? burst_load : (acc_seq && burst_cnt_q != 4'd0) ? burst_cnt_q - 4'd1 : burst_cnt_q;
        // The NONSEQ that opens a fixed-length burst must already lock the grant for its remaining beats
        hold        = (burst_cnt_q != 4'd0) | (acc_ns & (burst_load != 4'd0)) | own_lock | ~own_sw | own_trans[0];
        arb         = slv_HREADY & ~hold & (|req);
        credit_left = (acc_ns && credit_q != '0) ? credit_q - CW'(1) : credit_q;
        fp_found = 1'b0;
        fp_idx   = '0;
        fp_prio  = '0;
        for (int m = 0; m < MASTERS; m++) begin
            if (req[m] && (!fp_found || prio[m] > fp_prio)) begin
                fp_found = 1'b1;
                fp_prio  = prio[m];
                fp_idx   = MASTER_BITS'(m);
            end
        end
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = 1; k <= MASTERS; k++) begin
            j = int'(last_q) + k;
            if (j >= MASTERS) j = j - MASTERS;
            if (!rr_found && req[j]) begin
                rr_found = 1'b1;
                rr_idx   = MASTER_BITS'(j);
            end
        end
        st_found = 1'b0;
        st_idx   = '0;
        for (int m = MASTERS - 1; m >= 0; m--) begin
            if (starved[m] && req[m]) begin
                st_found = 1'b1;
                st_idx   = MASTER_BITS'(m);
            end
        end
        keep    = (ARB_MODE == 2) && !st_found && own_req && (credit_left != '0);
        win_idx = st_found ? st_idx : (ARB_MODE == 0) ? fp_idx : keep ? grant_idx_q : rr_idx;
        win_prio = '0;
        for (int m = 0; m < MASTERS; m++) begin
            if (win_idx == MASTER_BITS'(m)) win_prio = prio[m];
        end
        grant_idx_d = arb ? win_idx : grant_idx_q;
        last_d      = arb ? win_idx : last_q;
        credit_d    = (arb && !keep) ? CW'(win_prio) + CW'(1) : credit_left;
        data_d      = slv_HREADY ? ((own_req && own_trans[1]) ? granted_master : '0) : data_q;
        for (int m = 0; m < MASTERS; m++) begin
            wait_d[m] = (STARVE_LIMIT != 0 && req[m] && grant_idx_d != MASTER_BITS'(m)) ?
                        (starved[m] ? wait_q[m] : wait_q[m] + WW'(1)) : '0;
        end
    end

    // State registers; reset abandons any burst, lock hold or credit in progress
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_idx_q <= '0;
            last_q      <= MASTER_BITS'(MASTERS - 1);
            burst_cnt_q <= '0;
            credit_q    <= '0;
            data_q      <= '0;
            for (int m = 0; m < MASTERS; m++) wait_q[m] <= '0;
        end else begin
            grant_idx_q <= grant_idx_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            credit_q    <= credit_d;
            data_q      <= data_d;
            for (int m = 0; m < MASTERS; m++) wait_q[m] <= wait_d[m];
        end
    end

endmodule

// File: tb/tb_ahb3lite_slave_arbiter.sv
// tb_ahb3lite_slave_arbiter: directed checks of all arbitration modes, bursts, locking, starvation and reset
module tb_ahb3lite_slave_arbiter;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b1;
    logic [5:0] mst_priority;
    logic [2:0] mst_HSEL;
    logic [5:0] mst_HTRANS;
    logic [8:0] mst_HBURST;
    logic [2:0] mst_HMASTLOCK;
    logic [2:0] can_switch;
    logic       slv_HREADY;

    logic [2:0] gm [4];
    logic [1:0] gi [4];
    logic       gv [4];
    logic [2:0] dm [4];
    logic [2:0] sv [4];

    int n_chk = 0;
    int n_err = 0;

    localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SINGLE = 3'd0, INCR8 = 3'd5, INCR16 = 3'd7;

    always #5 HCLK = ~HCLK;

    // Instance 0: fixed priority; 1: round-robin; 2: weighted; 3: fixed priority with short starvation limit
    for (genvar i = 0; i < 4; i++) begin : g_dut
        ahb3lite_slave_arbiter #(
            .MASTERS(3),
            .ARB_MODE((i == 3) ? 0 : i),
            .STARVE_LIMIT((i == 0) ? 16 : (i == 3) ? 4 : 0)
        ) u_dut (
            .HCLK(HCLK),
            .HRESETn(HRESETn),
            .mst_priority(mst_priority),
            .mst_HSEL(mst_HSEL),
            .mst_HTRANS(mst_HTRANS),
            .mst_HBURST(mst_HBURST),
            .mst_HMASTLOCK(mst_HMASTLOCK),
            .can_switch(can_switch),
            .slv_HREADY(slv_HREADY),
            .granted_master(gm[i]),
            .grant_idx(gi[i]),
            .grant_valid(gv[i]),
            .data_master(dm[i]),
            .starved(sv[i])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_m(input int m, input logic sel, input logic [1:0] tr, input logic [2:0] bu);
        mst_HSEL[m]          = sel;
        mst_HTRANS[2*m +: 2] = tr;
        mst_HBURST[3*m +: 3] = bu;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_rr [4] = '{0, 1, 2, 0};
        int exp_st [6] = '{1, 1, 1, 1, 0, 1};
        int exp_sv [6] = '{0, 0, 0, 1, 0, 0};
        int exp_wr [7] = '{0, 0, 1, 0, 0, 1, 0};
        slv_HREADY    = 1'b1;
        can_switch    = 3'b111;
        mst_HMASTLOCK = 3'b000;
        mst_priority  = {2'd2, 2'd3, 2'd1};
        for (int m = 0; m < 3; m++) set_m(m, 1'b1, NONSEQ, SINGLE);
        #1 HRESETn = 1'b0;
        #1;
        check("rst_idx", gi[0], 0);
        check("rst_onehot", gm[0], 3'b001);
        check("rst_data", dm[0], 0);
        check("rst_starved", sv[0], 0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("fp_idx", gi[0], 1);
            check("fp_valid", gv[0], 1);
            check("rr_seq", gi[1], exp_rr[k]);
            if (k < 2) check("fp_data", dm[0], (k == 0) ? 3'b001 : 3'b010);
        end

        mst_priority = {2'd0, 2'd2, 2'd0};
        set_m(2, 1'b0, IDLE, SINGLE);
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step();
            check("starve_idx", gi[3], exp_st[k]);
            check("starve_flag", sv[3][0], exp_sv[k]);
        end

        mst_priority = {2'd0, 2'd0, 2'd1};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            step();
            check("wrr_seq", gi[2], exp_wr[k]);
        end
        mst_HMASTLOCK[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("wrr_lock", gi[2], 0);
        end
        mst_HMASTLOCK[0] = 1'b0;
        step();
        check("wrr_unlock", gi[2], 1);

        mst_priority = {2'd3, 2'd0, 2'd0};
        set_m(0, 1'b1, NONSEQ, INCR8);
        set_m(1, 1'b0, IDLE, SINGLE);
        set_m(2, 1'b1, NONSEQ, SINGLE);
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            step();
            check("burst_hold", gi[0], 0);
            if (k == 3) check("burst_wait_data", dm[0], 3'b001);
            mst_HTRANS[1:0] = (k <= 9) ? SEQ : IDLE;
            slv_HREADY      = (k == 2 || k == 3) ? 1'b0 : 1'b1;
        end
        step();
        check("burst_switch", gi[0], 2);
        check("burst_idle_data", dm[0], 0);
        step();
        check("burst_new_data", dm[0], 3'b100);
        mst_HSEL = 3'b000;
        for (int k = 0; k < 2; k++) begin
            step();
            check("park_idx", gi[0], 2);
            check("park_valid", gv[0], 0);
        end

        mst_priority = {2'd0, 2'd3, 2'd0};
        set_m(0, 1'b1, NONSEQ, INCR16);
        set_m(1, 1'b1, NONSEQ, SINGLE);
        set_m(2, 1'b0, IDLE, SINGLE);
        do_reset();
        step();
        check("b16_hold", gi[0], 0);
        mst_HTRANS[1:0] = SEQ;
        step();
        check("b16_hold", gi[0], 0);
        check("b16_data", dm[0], 3'b001);
        step();
        check("b16_hold", gi[0], 0);
        #3 HRESETn = 1'b0;
        #1;
        check("midrst_idx", gi[0], 0);
        check("midrst_onehot", gm[0], 3'b001);
        check("midrst_data", dm[0], 0);
        mst_HTRANS[1:0] = IDLE;
        @(negedge HCLK);
        HRESETn = 1'b1;
        step();
        check("midrst_regrant", gi[0], 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
